// File: rtl/wb_mem_responder.sv
// Wishbone classic memory responder with a fixed wait-state latency and read/write counters.
// Optional next-word read prefetch is enabled with the WB_MEM_PREFETCH_EN macro.
module wb_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h3800_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [15:0] rd_cnt_o,
  output logic [15:0] wr_cnt_o
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WinBytes = 32'(4 * DEPTH_WORDS);
  localparam bit          LatOne   = (LATENCY == 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            we_q, we_d;
  logic            ack_q;
  logic [31:0]     dat_q;
  logic [15:0]     rd_cnt_q, wr_cnt_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [31:0]     offset;
  logic            in_window, req, pf_hit, enter_ack, acc_we;
  logic [IdxW-1:0] req_idx, acc_idx;
  logic [31:0]     rd_word;

  assign offset    = wbs_adr_i - ADDR_BASE;
  assign in_window = (wbs_adr_i >= ADDR_BASE) && (offset < WinBytes);
  assign req       = wbs_stb_i & wbs_cyc_i & in_window;
  assign req_idx   = offset[IdxW+1:2];

  // From IDLE the access uses the live bus; from WAIT it uses the latched request.
  assign acc_idx = (state_q == StIdle) ? req_idx : idx_q;
  assign acc_we  = (state_q == StIdle) ? wbs_we_i : we_q;

`ifdef WB_MEM_PREFETCH_EN
  logic            pf_valid_q;
  logic [IdxW-1:0] pf_tag_q, nxt_idx;
  logic [31:0]     pf_data_q;

  assign nxt_idx = idx_q + IdxW'(1);
  assign pf_hit  = (state_q == StIdle) && pf_valid_q && !wbs_we_i && (req_idx == pf_tag_q);
  assign rd_word = pf_hit ? pf_data_q : mem_q[acc_idx];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pf_valid_q <= 1'b0;
      pf_tag_q   <= '0;
      pf_data_q  <= '0;
    end else if (state_q == StAck && !we_q) begin
      pf_valid_q <= 1'b1;
      pf_tag_q   <= nxt_idx;
      pf_data_q  <= mem_q[nxt_idx];
    end else if (enter_ack && acc_we && pf_valid_q && (acc_idx == pf_tag_q)) begin
      // Keep the prefetched copy coherent with the memory write.
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) pf_data_q[8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
    end
  end
`else
  assign pf_hit  = 1'b0;
  assign rd_word = mem_q[acc_idx];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    we_d      = we_q;
    enter_ack = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          idx_d = req_idx;
          we_d  = wbs_we_i;
          if (LatOne || pf_hit) begin
            state_d   = StAck;
            enter_ack = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 8'(LATENCY - 1);
          end
        end
      end
      StWait: begin
        if (!(wbs_stb_i && wbs_cyc_i)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == 8'd1) begin
          state_d   = StAck;
          cnt_d     = '0;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      ack_q   <= enter_ack;
      dat_q   <= (enter_ack && !acc_we) ? rd_word : 32'h0;
      if (enter_ack) begin
        if (acc_we) wr_cnt_q <= wr_cnt_q + 16'd1;
        else        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  // Memory is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && enter_ack && acc_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) mem_q[acc_idx][8*b +: 8] <= wbs_dat_i[8*b +: 8];
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign rd_cnt_o  = rd_cnt_q;
  assign wr_cnt_o  = wr_cnt_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Self-checking bench for wb_mem_responder: transaction-level model plus directed vectors.
// Expected prefetch latencies follow WB_MEM_PREFETCH_EN when it is defined.
module tb_wb_mem_responder;

  localparam logic [31:0] BASE  = 32'h3800_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 10;
`ifdef WB_MEM_PREFETCH_EN
  localparam bit Pf = 1'b1;
`else
  localparam bit Pf = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] wdat = '0, adr = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [15:0] rd_cnt, wr_cnt;

  always #5 clk = ~clk;

  wb_mem_responder #(
    .ADDR_BASE  (BASE),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_dat_i(wdat),
    .wbs_adr_i(adr),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .rd_cnt_o (rd_cnt),
    .wr_cnt_o (wr_cnt)
  );

  int n_checks = 0, n_fail = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Model state
  logic [31:0] ref_mem [DEPTH];
  int          m_rd = 0, m_wr = 0, exp_ack_cyc = -1, pf_tag = -1;
  logic [31:0] exp_dat = '0;
  bit          chk_en = 1'b0;
  int          last_ack_cyc = -1, last_lat = 0;
  logic [31:0] last_dat = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc_n);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic e_ack;
    if (chk_en) begin
      e_ack = (cyc_n == exp_ack_cyc);
      check("ack", 32'(ack), 32'(e_ack));
      check("dat_o", rdat, e_ack ? exp_dat : 32'h0);
      check("rd_cnt", 32'(rd_cnt), 32'(m_rd));
      check("wr_cnt", 32'(wr_cnt), 32'(m_wr));
      if (ack) begin
        last_ack_cyc = cyc_n;
        last_dat     = rdat;
      end
    end
  end

  // Complete one transfer; called #1 after a rising edge, returns at the same phase.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d);
    int idx, lat, p;
    idx = int'((a - BASE) >> 2);
    lat = (!w && Pf && pf_tag == idx) ? 1 : LAT;
    p = cyc_n;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; wdat = d;
    exp_dat     = w ? 32'h0 : ref_mem[idx];
    exp_ack_cyc = p + lat;
    while (cyc_n < exp_ack_cyc) begin
      @(posedge clk); #1;
    end
    if (w) begin
      for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      m_wr = (m_wr + 1) % 65536;
    end else begin
      m_rd   = (m_rd + 1) % 65536;
      pf_tag = (idx + 1) % DEPTH;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    exp_ack_cyc = -1;
    last_lat = last_ack_cyc - p;
  endtask

  task automatic model_reset();
    m_rd = 0; m_wr = 0; pf_tag = -1; exp_ack_cyc = -1;
  endtask

  initial begin
    int p;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("reset ack", 32'(ack), 32'h0);
    check("reset dat", rdat, 32'h0);
    check("reset rd_cnt", 32'(rd_cnt), 32'h0);
    check("reset wr_cnt", 32'(wr_cnt), 32'h0);

    // Full-word write then read back
    xfer(1'b1, BASE + 8, 4'hF, 32'hDEAD_BEEF);
    check("write latency", last_lat, 10);
    xfer(1'b0, BASE + 8, 4'hF, 32'h0);
    check("read latency", last_lat, 10);
    check("read data", last_dat, 32'hDEAD_BEEF);
    check("wr_cnt after 1", 32'(wr_cnt), 32'd1);
    check("rd_cnt after 1", 32'(rd_cnt), 32'd1);

    // Byte-enable merge; read with partial sel still returns the full word
    xfer(1'b1, BASE + 20, 4'hF, 32'hFFFF_FFFF);
    xfer(1'b1, BASE + 20, 4'h5, 32'h1122_3344);
    xfer(1'b0, BASE + 20, 4'h1, 32'h0);
    check("sel merge", last_dat, 32'hFF22_FF44);

    // Write aborted in its 4th WAIT cycle
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 20; sel = 4'hF; wdat = 32'h0;
    repeat (4) @(posedge clk);
    #1 stb = 1'b0;
    @(posedge clk); #1 cyc = 1'b0; we = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("abort wr_cnt", 32'(wr_cnt), 32'd3);
    xfer(1'b0, BASE + 20, 4'hF, 32'h0);
    check("abort mem kept", last_dat, 32'hFF22_FF44);
    xfer(1'b1, BASE + 24, 4'hF, 32'hCAFE_F00D);
    check("post-abort write latency", last_lat, 10);
    xfer(1'b0, BASE + 24, 4'hF, 32'h0);
    check("prefetch-coherent read", last_dat, 32'hCAFE_F00D);
    check("tagged read latency", last_lat, Pf ? 1 : 10);

    // Out-of-window request is never acknowledged
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 4 * DEPTH; sel = 4'hF;
    repeat (3 * LAT) begin @(posedge clk); #1; end
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a read's WAIT
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 8;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1; stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; model_reset();
    check("rst mid-wait rd_cnt", 32'(rd_cnt), 32'h0);

    // Reset on the edge that would enter ACK drops the write
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE + 8; sel = 4'hF; wdat = 32'h0;
    p = cyc_n;
    while (cyc_n < p + LAT - 1) begin @(posedge clk); #1; end
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; model_reset();
    xfer(1'b0, BASE + 8, 4'hF, 32'h0);
    check("post-reset latency", last_lat, 10);
    check("mem survives reset", last_dat, 32'hDEAD_BEEF);
    check("post-reset rd_cnt", 32'(rd_cnt), 32'd1);
    check("post-reset wr_cnt", 32'(wr_cnt), 32'd0);

    // Sequential burst
    for (int i = 0; i < 64; i++) xfer(1'b1, BASE + 32'(4 * i), 4'hF, {16'hA5A5, 16'(i)});
    for (int i = 0; i < 64; i++) begin
      xfer(1'b0, BASE + 32'(4 * i), 4'hF, 32'h0);
      check("burst latency", last_lat, (i == 0 || !Pf) ? 10 : 1);
      check("burst data", last_dat, {16'hA5A5, 16'(i)});
    end
    check("burst rd_cnt", 32'(rd_cnt), 32'd65);

    // Index wrap from the last word back to word 0
    xfer(1'b1, BASE + 4 * (DEPTH - 1), 4'hF, 32'h5A5A_1234);
    xfer(1'b0, BASE + 4 * (DEPTH - 1), 4'hF, 32'h0);
    check("top word", last_dat, 32'h5A5A_1234);
    xfer(1'b0, BASE, 4'hF, 32'h0);
    check("wrap latency", last_lat, Pf ? 1 : 10);
    check("wrap data", last_dat, 32'hA5A5_0000);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
